regfile_wb_scheduler: RTL and testbench

- Shares the register file's single write port between NREQ writeback requesters using round-robin arbitration and a valid/ready handshake.
- Keeps a 32-entry busy scoreboard. Issue logic reserves a destination register; the scoreboard flags RAW hazards on the two read addresses.
- Sits between the execute/load/CSR writeback sources and the 64-bit register file.

---
 rtl/regfile_wb_scheduler_if.sv | 24 ++
 rtl/regfile_wb_scheduler.sv | 103 ++++++++++
 tb/tb_regfile_wb_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback bus between the requesters and the register-file write port.
// The scheduler takes the slave side; the requesters and register file take the master side.
interface regfile_wb_scheduler_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = 64
) ();
  logic [NREQ-1:0]      req_valid;
  logic [5*NREQ-1:0]    req_addr;
  logic [XLEN*NREQ-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic [4:0]           rf_rd_addr;
  logic [XLEN-1:0]      rf_rd_data;
  logic                 rf_reg_write;

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_rd_addr, rf_rd_data, rf_reg_write
  );

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_rd_addr, rf_rd_data, rf_reg_write
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin writeback arbiter for the single register-file write port,
// plus a 32-entry busy scoreboard for RAW hazard detection.
module regfile_wb_scheduler #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  regfile_wb_scheduler_if.slave        bus,
  input  logic                         rsv_valid,
  input  logic [4:0]                   rsv_addr,
  output logic                         rsv_ok,
  input  logic [4:0]                   rs1_addr,
  input  logic [4:0]                   rs2_addr,
  output logic                         rs1_busy,
  output logic                         rs2_busy,
  output logic [31:0]                  busy_vec,
  output logic                         idle
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic            found;
  logic [PW-1:0]   gidx;
  logic [4:0]      win_addr;
  logic [XLEN-1:0] win_data;
  logic            do_write;
  logic            do_set;
  logic [31:0]     busy_next;

  // Pick the first valid requester at or after ptr, wrapping to the front.
  // Two ascending passes (i >= ptr, then i < ptr) give the modulo scan order.
  always_comb begin
    found    = 1'b0;
    gidx     = '0;
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && (i >= 32'(ptr)) && bus.req_valid[i]) begin
        found    = 1'b1;
        gidx     = PW'(i);
        win_addr = bus.req_addr[5*i +: 5];
        win_data = bus.req_data[XLEN*i +: XLEN];
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && (i < 32'(ptr)) && bus.req_valid[i]) begin
        found    = 1'b1;
        gidx     = PW'(i);
        win_addr = bus.req_addr[5*i +: 5];
        win_data = bus.req_data[XLEN*i +: XLEN];
      end
    end
  end

  // Drive the write port and handshake; everything is held quiet while in reset.
  always_comb begin
    bus.req_ready    = '0;
    bus.rf_rd_addr   = '0;
    bus.rf_rd_data   = '0;
    bus.rf_reg_write = 1'b0;
    if (rst_n && found) begin
      bus.req_ready[gidx] = 1'b1;
      bus.rf_rd_addr      = win_addr;
      bus.rf_rd_data      = win_data;
      bus.rf_reg_write    = (win_addr != 5'd0);
    end
  end

  // Reservation acceptance and hazard lookups from current scoreboard state.
  always_comb begin
    rsv_ok   = rst_n && rsv_valid && ((rsv_addr == 5'd0) || !busy_vec[rsv_addr]);
    rs1_busy = busy_vec[rs1_addr];
    rs2_busy = busy_vec[rs2_addr];
    idle     = (busy_vec == '0) && (bus.req_valid == '0);
  end

  // Next scoreboard: clear on writeback, then set on reservation so set wins.
  always_comb begin
    do_write  = bus.rf_reg_write;
    do_set    = rsv_ok && (rsv_addr != 5'd0);
    busy_next = busy_vec;
    if (do_write) busy_next[bus.rf_rd_addr] = 1'b0;
    if (do_set)   busy_next[rsv_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Priority pointer advances past each winner; scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
      if (found) begin
        if (gidx == PW'(NREQ - 1)) ptr <= '0;
        else                       ptr <= gidx + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: vector table plus hand-written
// sequences for reset, hazard lifecycle and same-cycle set/clear.
module tb_regfile_wb_scheduler;

  localparam int unsigned NREQ = 3;
  localparam int unsigned XLEN = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rsv_valid;
  logic [4:0]  rsv_addr, rs1_addr, rs2_addr;
  logic        rsv_ok, rs1_busy, rs2_busy, idle;
  logic [31:0] busy_vec;

  regfile_wb_scheduler_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

  regfile_wb_scheduler #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_vec(busy_vec), .idle(idle)
  );

  always #5 clk = ~clk;

  // Register file model fed by the write port.
  logic [63:0] regs [32];
  initial for (int i = 0; i < 32; i++) regs[i] = '0;
  always @(posedge clk) if (bus.rf_reg_write) regs[bus.rf_rd_addr] <= bus.rf_rd_data;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] gdat(input int v, input int r);
    return {32'hC0DE0000, 16'(v), 16'(r)};
  endfunction

  typedef struct {
    logic [2:0]  rv;
    logic [4:0]  a0, a1, a2;
    logic        rsv_v;
    logic [4:0]  rsv_a;
    logic [2:0]  e_ready;
    logic        e_we;
    logic [4:0]  e_addr;
    logic        e_ok;
    logic        e_idle;
    logic [31:0] e_busy;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] rv, input logic [4:0] a0, a1, a2,
                              input logic rsv_v, input logic [4:0] rsv_a,
                              input logic [2:0] e_ready, input logic e_we,
                              input logic [4:0] e_addr, input logic e_ok,
                              input logic e_idle, input logic [31:0] e_busy);
    vec_t v;
    v.rv = rv; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.rsv_v = rsv_v; v.rsv_a = rsv_a;
    v.e_ready = e_ready; v.e_we = e_we; v.e_addr = e_addr; v.e_ok = e_ok;
    v.e_idle = e_idle; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic drive(input logic [2:0] rv, input logic [4:0] a0, a1, a2,
                       input logic [63:0] d0, d1, d2);
    bus.req_valid = rv;
    bus.req_addr  = {a2, a1, a0};
    bus.req_data  = {d2, d1, d0};
  endtask

  vec_t tbl [19];

  initial begin
    logic [63:0] exp_data;
    int w;

    // Table: pointer starts at 0 after the mid-transfer reset.
    for (int i = 0; i < 6; i++) begin
      logic [2:0] oh;
      oh = 3'b001 << (i % 3);
      tbl[i] = mk(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, oh, 1'b1, 5'((i % 3) + 1), 1'b0, 1'b0, 32'h0);
    end
    // x0 write from requester 2 plus reservation of x0.
    tbl[6] = mk(3'b100, 5'd4, 5'd5, 5'd0, 1'b1, 5'd0, 3'b100, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0);
    // Pointer wrapped to 0 after granting requester 2.
    tbl[7] = mk(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 3'b001, 1'b1, 5'd1, 1'b0, 1'b0, 32'h0);
    // Ten idle cycles; pointer must stay at 1.
    for (int i = 8; i < 18; i++)
      tbl[i] = mk(3'b000, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0);
    tbl[18] = mk(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 3'b010, 1'b1, 5'd2, 1'b0, 1'b0, 32'h0);

    rsv_valid = 1'b0; rsv_addr = '0; rs1_addr = 5'd1; rs2_addr = 5'd2;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 64'h3);

    // Reset state with requests pending.
    #12;
    chk("rst_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_we", 64'(bus.rf_reg_write), 64'h0);
    chk("rst_addr", 64'(bus.rf_rd_addr), 64'h0);
    chk("rst_data", bus.rf_rd_data, 64'h0);
    chk("rst_busy", 64'(busy_vec), 64'h0);
    @(negedge clk); rst_n = 1'b1;

    // Move the pointer off 0: grant requester 1 alone.
    drive(3'b010, 5'd1, 5'd6, 5'd3, 64'h1, 64'h66, 64'h3);
    #1 chk("pre_grant1", 64'(bus.req_ready), 64'h2);
    @(posedge clk);

    // Reset mid-transfer: request to reg5 dropped.
    @(negedge clk);
    drive(3'b001, 5'd5, 5'd0, 5'd0, 64'h55, 64'h0, 64'h0);
    #1 chk("mt_ready_pre", 64'(bus.req_ready), 64'h1);
    #1 rst_n = 1'b0;
    #1 chk("mt_ready_rst", 64'(bus.req_ready), 64'h0);
    chk("mt_we_rst", 64'(bus.rf_reg_write), 64'h0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1; bus.req_valid = '0;
    #1 chk("mt_reg5", regs[5], 64'h0);
    chk("mt_busy", 64'(busy_vec), 64'h0);

    // Table-driven vectors.
    for (int v = 0; v < 19; v++) begin
      @(negedge clk);
      drive(tbl[v].rv, tbl[v].a0, tbl[v].a1, tbl[v].a2, gdat(v, 0), gdat(v, 1), gdat(v, 2));
      rsv_valid = tbl[v].rsv_v; rsv_addr = tbl[v].rsv_a;
      w = -1;
      for (int r = 0; r < 3; r++) if (tbl[v].e_ready[r]) w = r;
      exp_data = (w < 0) ? 64'h0 : gdat(v, w);
      #1;
      chk($sformatf("v%0d_ready", v), 64'(bus.req_ready), 64'(tbl[v].e_ready));
      chk($sformatf("v%0d_we", v), 64'(bus.rf_reg_write), 64'(tbl[v].e_we));
      chk($sformatf("v%0d_addr", v), 64'(bus.rf_rd_addr), 64'(tbl[v].e_addr));
      chk($sformatf("v%0d_data", v), bus.rf_rd_data, exp_data);
      chk($sformatf("v%0d_rsvok", v), 64'(rsv_ok), 64'(tbl[v].e_ok));
      chk($sformatf("v%0d_idle", v), 64'(idle), 64'(tbl[v].e_idle));
      chk($sformatf("v%0d_rsbusy", v), 64'({rs1_busy, rs2_busy}), 64'h0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_busy", v), 64'(busy_vec), 64'(tbl[v].e_busy));
    end
    chk("rr_reg3", regs[3], gdat(5, 2));

    // Hazard lifecycle on reg7 (pointer now 2).
    @(negedge clk);
    bus.req_valid = '0; rsv_valid = 1'b1; rsv_addr = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd3;
    #1 chk("hz_rsv1_ok", 64'(rsv_ok), 64'h1);
    chk("hz_rs1_pre", 64'(rs1_busy), 64'h0);
    @(posedge clk); #1 chk("hz_busy7", 64'(busy_vec), 64'h80);
    @(negedge clk);
    #1 chk("hz_rsv2_ok", 64'(rsv_ok), 64'h0);
    chk("hz_rs1_busy", 64'(rs1_busy), 64'h1);
    chk("hz_rs2_busy", 64'(rs2_busy), 64'h0);
    chk("hz_idle", 64'(idle), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rsv_valid = 1'b0;
    drive(3'b010, 5'd0, 5'd7, 5'd0, 64'h0, 64'hDEAD, 64'h0);
    #1 chk("hz_wr_ready", 64'(bus.req_ready), 64'h2);
    chk("hz_wr_addr", 64'(bus.rf_rd_addr), 64'h7);
    chk("hz_wr_data", bus.rf_rd_data, 64'hDEAD);
    @(posedge clk); #1;
    chk("hz_busy_clr", 64'(busy_vec), 64'h0);
    chk("hz_reg7", regs[7], 64'hDEAD);

    // Same-cycle set/clear on reg9 (pointer now 2, scan reaches requester 0).
    @(negedge clk);
    drive(3'b001, 5'd9, 5'd0, 5'd0, 64'h99, 64'h0, 64'h0);
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    #1 chk("cf1_ok", 64'(rsv_ok), 64'h1);
    chk("cf1_we", 64'(bus.rf_reg_write), 64'h1);
    @(posedge clk); #1 chk("cf1_busy", 64'(busy_vec), 64'h200);
    @(negedge clk);
    #1 chk("cf2_ok", 64'(rsv_ok), 64'h0);
    chk("cf2_we", 64'(bus.rf_reg_write), 64'h1);
    @(posedge clk); #1 chk("cf2_busy", 64'(busy_vec), 64'h0);

    @(negedge clk);
    bus.req_valid = '0; rsv_valid = 1'b0;
    #1 chk("end_idle", 64'(idle), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
